// File: rtl/ccff_pkg.sv
// Shared definitions for the CCFF configuration-chain loader:
// FSM state encoding, per-tile chain lengths, counter width and word-count helper.
// The CHECK state exists only when CCFF_CHAIN_LOADER_READBACK_EN is defined.
package ccff_pkg;

  // Default chain lengths per tile type
  localparam int CBX_CHAIN_LEN = 10;  // 3+3+2+2: two size-6 and two size-2 muxes
  localparam int CBY_CHAIN_LEN = 10;
  localparam int SB_CHAIN_LEN  = 24;

  localparam int CCFF_WORD_W = 8;

  // bit_cnt must hold the value CHAIN_LEN itself, hence the +1
  localparam int CCFF_CNT_W = $clog2(CBX_CHAIN_LEN + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    ,
    ST_CHECK = 3'd4
`endif
  } ccff_state_e;

  // Number of words a full load consumes: ceil(chain_len / word_w)
  function automatic int ccff_word_count(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Holds one configuration word and presents it LSB first, one bit per shift.
// last_o flags that the bit currently presented is the top bit of the word.
module ccff_word_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              shift_i,
  output logic              bit_o,
  output logic              last_o
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  // Load restarts the index at bit 0; each shift advances to the next bit
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (load_i) begin
      word_d = data_i;
      idx_d  = '0;
    end else if (shift_i) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // Word and index registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign bit_o  = word_q[idx_q];
  assign last_o = (idx_q == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises configuration words into one tile's CCFF scan chain.
// Bit 0 of each word is shifted first, so the first stream bit lands in the
// tail-most memory cell. Exactly CHAIN_LEN shift cycles are issued per load.
// Optional build macro CCFF_CHAIN_LOADER_READBACK_EN adds a rotate-and-compare
// CHECK pass after the load and a cfg_err output.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = CBX_CHAIN_LEN,
  parameter int WORD_W    = CCFF_WORD_W
) (
  input  logic                           prog_clk,
  input  logic                           prog_reset,
  input  logic                           start,
  input  logic [WORD_W-1:0]              cfg_data,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  output logic                           ccff_head,
  output logic                           ccff_shift_en,
  input  logic                           ccff_tail,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(CHAIN_LEN+1)-1:0] bit_cnt
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  ,
  output logic                           cfg_err
`endif
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);

  ccff_state_e state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic ser_load;
  logic ser_shift;
  logic ser_bit;
  logic ser_last;
  logic last_shift;

  // Handshake happens only in FETCH; the serializer advances only in SHIFT
  assign ser_load   = (state_q == ST_FETCH) && cfg_valid;
  assign ser_shift  = (state_q == ST_SHIFT);
  assign last_shift = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));

  ccff_word_serializer #(
    .WORD_W (WORD_W)
  ) u_serializer (
    .clk_i   (prog_clk),
    .rst_i   (prog_reset),
    .load_i  (ser_load),
    .data_i  (cfg_data),
    .shift_i (ser_shift),
    .bit_o   (ser_bit),
    .last_o  (ser_last)
  );

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  // Shadow fills from the top so the first shifted bit ends up in bit 0,
  // matching the order in which the tail returns bits during CHECK.
  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]     chk_cnt_q, chk_cnt_d;
  logic                 err_q, err_d;
  logic                 chk_last;

  assign chk_last = (chk_cnt_q == CNT_W'(CHAIN_LEN - 1));
`else
  // Tail is only observed by the readback pass
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

  // Next-state logic for the load FSM and its counters
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    shadow_d  = shadow_q;
    chk_cnt_d = chk_cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      // A start from DONE goes straight to FETCH; no IDLE cycle is spent
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_FETCH;
          bit_cnt_d = '0;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
          chk_cnt_d = '0;
          err_d     = 1'b0;
`endif
        end
      end
      ST_FETCH: begin
        if (cfg_valid) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
        shadow_d  = {ser_bit, shadow_q[CHAIN_LEN-1:1]};
`endif
        // The chain length wins over the word boundary: leftover word bits are dropped
        if (last_shift) begin
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end else if (ser_last) begin
          state_d = ST_FETCH;
        end
      end
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
      // Rotate the chain once around, comparing each returning bit to the shadow
      ST_CHECK: begin
        chk_cnt_d = chk_cnt_q + 1'b1;
        shadow_d  = {shadow_q[0], shadow_q[CHAIN_LEN-1:1]};
        if (ccff_tail != shadow_q[0]) begin
          err_d = 1'b1;
        end
        if (chk_last) begin
          state_d = ST_DONE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers; reset drops shift enable immediately
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  // Readback shadow, check counter and sticky error flag
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      shadow_q  <= '0;
      chk_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      chk_cnt_q <= chk_cnt_d;
      err_q     <= err_d;
    end
  end

  assign cfg_err       = err_q;
  assign ccff_shift_en = (state_q == ST_SHIFT) || (state_q == ST_CHECK);
  assign busy          = (state_q == ST_FETCH) || (state_q == ST_SHIFT) || (state_q == ST_CHECK);
  assign ccff_head     = (state_q == ST_SHIFT) ? ser_bit :
                         (state_q == ST_CHECK) ? ccff_tail : 1'b0;
`else
  assign ccff_shift_en = (state_q == ST_SHIFT);
  assign busy          = (state_q == ST_FETCH) || (state_q == ST_SHIFT);
  assign ccff_head     = (state_q == ST_SHIFT) ? ser_bit : 1'b0;
`endif

  // cfg_ready depends on state only, never on cfg_valid
  assign cfg_ready = (state_q == ST_FETCH);
  assign done      = (state_q == ST_DONE);
  assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench for ccff_chain_loader (CHAIN_LEN=10, WORD_W=8).
// A behavioural chain model sits on ccff_head/ccff_tail; expected head bits
// are queued when words are driven and popped on each shift cycle.
// Readback scenarios are included when CCFF_CHAIN_LOADER_READBACK_EN is defined.
module tb_ccff_chain_loader;
  import ccff_pkg::*;

  localparam int L     = 10;
  localparam int W     = 8;
  localparam int CW    = $clog2(L + 1);
  localparam int NW    = ccff_word_count(L, W);
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  localparam int LAT   = L + NW + L;
  localparam int SHN   = 2 * L;
`else
  localparam int LAT   = L + NW;
  localparam int SHN   = L;
`endif

  logic          clk = 1'b0;
  logic          prog_reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  cfg_data = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic          ccff_head;
  logic          ccff_shift_en;
  logic          ccff_tail;
  logic          busy;
  logic          done;
  logic [CW-1:0] bit_cnt;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  logic          cfg_err;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Chain model: cell 0 is nearest the head, cell L-1 drives the tail
  logic [L-1:0] chain = '0;
  logic [L-1:0] stuck_mask = '0;
  logic [L-1:0] exp_chain;

  // Scoreboard and load bookkeeping
  bit           exp_q[$];
  logic [W-1:0] words[2];
  int           word_ptr, gap_len, gap_left, sh_cnt, start_cyc, done_cyc;
  int           pulse_a = -1, pulse_b = -1;
  bit           gap_bad, nonmono;
  logic [L-1:0] gap_snap;
  logic [CW-1:0] prev_bit_cnt;
  logic         ready_after_start, done_after_start, busy_after_start;

  ccff_chain_loader #(
    .CHAIN_LEN (L),
    .WORD_W    (W)
  ) dut (
    .prog_clk      (clk),
    .prog_reset    (prog_reset),
    .start         (start),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .bit_cnt       (bit_cnt)
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    ,
    .cfg_err       (cfg_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ccff_shift_en) chain <= {chain[L-2:0], ccff_head} & ~stuck_mask;
  end

  assign ccff_tail = chain[L-1];

  // One clock of a load: scoreboard pop on shift, gap/monotonic tracking, then drive
  task automatic step();
    bit hs;
    bit exp_b;
    int rel;
    @(negedge clk);
    if (ccff_shift_en) begin
      if (sh_cnt < L) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL head_bit%0d: shift with empty scoreboard, head=%b", sh_cnt, ccff_head);
        end else begin
          exp_b = exp_q.pop_front();
          if (ccff_head !== exp_b) begin
            errors++;
            $display("FAIL head_bit%0d: got %b expected %b", sh_cnt, ccff_head, exp_b);
          end
        end
      end
      sh_cnt++;
    end
    if (bit_cnt < prev_bit_cnt) nonmono = 1'b1;
    prev_bit_cnt = bit_cnt;
    if (cfg_ready && !cfg_valid && gap_left > 0) begin
      if (gap_left == gap_len) gap_snap = chain;
      else if (chain !== gap_snap) gap_bad = 1'b1;
      if (ccff_shift_en) gap_bad = 1'b1;
      gap_left--;
    end
    if (done && done_cyc < 0) done_cyc = cyc;
    hs = cfg_ready && cfg_valid;
    @(posedge clk);
    #1;
    rel = cyc - start_cyc;
    start = (rel == pulse_a) || (rel == pulse_b);
    if (hs) begin
      word_ptr++;
      if (word_ptr < 2) cfg_data = words[word_ptr];
      if (word_ptr == 1 && gap_left > 0) cfg_valid = 1'b0;
    end else if (!cfg_valid && gap_left == 0) begin
      cfg_valid = 1'b1;
    end
  endtask

  // Drive a full two-word load and run until done (bounded)
  task automatic run_load(input logic [W-1:0] w0, input logic [W-1:0] w1,
                          input int gap, input int pa, input int pb);
    logic [2*W-1:0] stream;
    words[0] = w0;
    words[1] = w1;
    stream = {w1, w0};
    exp_q.delete();
    exp_chain = '0;
    for (int k = 0; k < L; k++) begin
      exp_q.push_back(stream[k]);
      exp_chain[L-1-k] = stream[k];
    end
    word_ptr = 0; gap_len = gap; gap_left = gap; gap_bad = 0; nonmono = 0;
    sh_cnt = 0; done_cyc = -1; pulse_a = pa; pulse_b = pb;
    cfg_data = w0;
    cfg_valid = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
    ready_after_start = cfg_ready;
    done_after_start = done;
    busy_after_start = busy;
    prev_bit_cnt = bit_cnt;
    for (int n = 0; n < 200 && done_cyc < 0; n++) step();
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL load_timeout: done=%b after 200 cycles, required 1", done);
    end
  endtask

  task automatic test_reset();
    prog_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_cfg_ready: got %b expected 0", cfg_ready); end
    checks++; if (ccff_shift_en !== 1'b0) begin errors++; $display("FAIL reset_shift_en: got %b expected 0", ccff_shift_en); end
    checks++; if (ccff_head !== 1'b0) begin errors++; $display("FAIL reset_head: got %b expected 0", ccff_head); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (bit_cnt !== '0) begin errors++; $display("FAIL reset_bit_cnt: got %0d expected 0", bit_cnt); end
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); end
`endif
    prog_reset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_start_busy: got %b expected 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_basic_load();
    run_load(8'hA5, 8'h03, 0, -1, -1);
    checks++; if (done_cyc - start_cyc != LAT) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", done_cyc - start_cyc, LAT); end
    checks++; if (busy_after_start !== 1'b1) begin errors++; $display("FAIL basic_busy_fetch: got %b expected 1", busy_after_start); end
    step(); step();
    checks++; if (sh_cnt != SHN) begin errors++; $display("FAIL basic_shift_count: got %0d expected %0d", sh_cnt, SHN); end
    checks++; if (chain !== exp_chain) begin errors++; $display("FAIL basic_chain: got %b expected %b", chain, exp_chain); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_leftover: got %0d expected 0", exp_q.size()); end
    checks++; if (bit_cnt !== CW'(L)) begin errors++; $display("FAIL basic_bit_cnt: got %0d expected %0d", bit_cnt, L); end
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL basic_done_state: busy=%b done=%b expected 0/1", busy, done); end
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL basic_cfg_err: got %b expected 0", cfg_err); end
`endif
    $display("test_basic_load words A5 03 latency %0d shifts %0d", done_cyc - start_cyc, sh_cnt);
  endtask

  task automatic test_valid_gap();
    run_load(8'hA5, 8'h03, 5, -1, -1);
    checks++; if (done_cyc - start_cyc != LAT + 5) begin errors++; $display("FAIL gap_latency: got %0d expected %0d", done_cyc - start_cyc, LAT + 5); end
    checks++; if (gap_left != 0 || gap_bad) begin errors++; $display("FAIL gap_hold: left=%0d bad=%b expected 0/0", gap_left, gap_bad); end
    checks++; if (sh_cnt != SHN) begin errors++; $display("FAIL gap_shift_count: got %0d expected %0d", sh_cnt, SHN); end
    checks++; if (chain !== exp_chain) begin errors++; $display("FAIL gap_chain: got %b expected %b", chain, exp_chain); end
    $display("test_valid_gap latency %0d", done_cyc - start_cyc);
  endtask

  task automatic test_start_ignored();
    run_load(8'h3C, 8'h02, 0, 3, 6);
    checks++; if (nonmono) begin errors++; $display("FAIL busy_start_bit_cnt: got non-monotonic expected monotonic"); end
    checks++; if (sh_cnt != SHN) begin errors++; $display("FAIL busy_start_shifts: got %0d expected %0d", sh_cnt, SHN); end
    checks++; if (done_cyc - start_cyc != LAT) begin errors++; $display("FAIL busy_start_latency: got %0d expected %0d", done_cyc - start_cyc, LAT); end
    checks++; if (chain !== exp_chain) begin errors++; $display("FAIL busy_start_chain: got %b expected %b", chain, exp_chain); end
    $display("test_start_ignored shifts %0d", sh_cnt);
  endtask

  task automatic test_restart_from_done();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart_pre_done: got %b expected 1", done); end
    run_load(8'h81, 8'h01, 0, -1, -1);
    checks++; if (done_after_start !== 1'b0) begin errors++; $display("FAIL restart_done_clear: got %b expected 0", done_after_start); end
    checks++; if (ready_after_start !== 1'b1) begin errors++; $display("FAIL restart_ready: got %b expected 1", ready_after_start); end
    checks++; if (chain !== exp_chain) begin errors++; $display("FAIL restart_chain: got %b expected %b", chain, exp_chain); end
    $display("test_restart_from_done latency %0d", done_cyc - start_cyc);
  endtask

  task automatic test_reset_mid_shift();
    logic [L-1:0] snap;
    bit found;
    cfg_data = 8'h5A;
    cfg_valid = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (ccff_shift_en && bit_cnt == CW'(4)) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL midreset_reach: bit_cnt=%0d never reached 4", bit_cnt); end
    #1;
    prog_reset = 1'b1;
    #1;
    checks++; if (ccff_shift_en !== 1'b0) begin errors++; $display("FAIL midreset_shift_en: got %b expected 0", ccff_shift_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (bit_cnt !== '0) begin errors++; $display("FAIL midreset_bit_cnt: got %0d expected 0", bit_cnt); end
    snap = chain;
    @(posedge clk);
    #1;
    checks++; if (chain !== snap) begin errors++; $display("FAIL midreset_chain_hold: got %b expected %b", chain, snap); end
    prog_reset = 1'b0;
    run_load(8'hC3, 8'h02, 0, -1, -1);
    checks++; if (done_cyc - start_cyc != LAT) begin errors++; $display("FAIL midreset_reload_latency: got %0d expected %0d", done_cyc - start_cyc, LAT); end
    checks++; if (chain !== exp_chain) begin errors++; $display("FAIL midreset_reload_chain: got %b expected %b", chain, exp_chain); end
    $display("test_reset_mid_shift reload shifts %0d", sh_cnt);
  endtask

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  task automatic test_readback_stuck();
    stuck_mask = '0;
    stuck_mask[6] = 1'b1;
    run_load(8'hA5, 8'h03, 0, -1, -1);
    stuck_mask = '0;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL stuck_cfg_err: got %b expected 1", cfg_err); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stuck_done: got %b expected 1", done); end
    checks++; if (sh_cnt != 2 * L) begin errors++; $display("FAIL stuck_shifts: got %0d expected %0d", sh_cnt, 2 * L); end
    $display("test_readback_stuck cfg_err %b shifts %0d", cfg_err, sh_cnt);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_valid_gap();
    test_start_ignored();
    test_restart_from_done();
    test_reset_mid_shift();
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    test_readback_stuck();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
